// File: rtl/dot_matrix_scan_capture_if.sv
// ---------------------------------------------------------------------------
// dot_matrix_scan_capture_if
// Scan bus of the 8x8 bicolor dot-matrix display.
//   hang  : row select, bit i selects row i (polarity set by the sink)
//   red   : red column data of the selected row, bit j = column j, 1 = lit
//   green : green column data of the selected row, same encoding as red
// master modport = pattern generator (drives the bus)
// slave  modport = display / capture monitor (samples the bus)
// ---------------------------------------------------------------------------
interface dot_matrix_scan_capture_if;
    logic [7:0] hang;
    logic [7:0] red;
    logic [7:0] green;

    modport master (output hang, output red, output green);
    modport slave  (input  hang, input  red, input  green);
endinterface

// File: rtl/dot_matrix_scan_capture.sv
// ---------------------------------------------------------------------------
// dot_matrix_scan_capture
// Sink-side monitor for the 8x8 bicolor dot-matrix scan bus. Samples the bus,
// checks the row scan order, reassembles a full red/green frame in a shadow
// buffer and commits it atomically to a committed buffer that feeds the
// combinational read port.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   scan (slave)        : hang / red / green scan bus
//   rd_row              : read address into the committed frame
//   rd_red, rd_green    : committed row data at rd_row (combinational)
//   frame_valid         : 1-cycle pulse, new frame committed
//   frame_changed       : 1-cycle pulse with frame_valid if the frame differs
//   scan_err            : 1-cycle pulse on an illegal or out-of-order row
//   frame_cnt, err_cnt  : saturating event counters
// ---------------------------------------------------------------------------
module dot_matrix_scan_capture #(
    parameter bit ROW_ACTIVE_LOW = 1'b1,
    parameter int CNT_W          = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    dot_matrix_scan_capture_if.slave     scan,
    input  logic [2:0]                   rd_row,
    output logic [7:0]                   rd_red,
    output logic [7:0]                   rd_green,
    output logic                         frame_valid,
    output logic                         frame_changed,
    output logic                         scan_err,
    output logic [CNT_W-1:0]             frame_cnt,
    output logic [CNT_W-1:0]             err_cnt
);

    typedef enum logic {SYNC = 1'b0, CAPTURE = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [2:0]        exp_q, exp_d;

    // Input stage. hang is stored already converted to active-high, so the
    // cleared value means "no row selected" rather than "all rows selected".
    logic [7:0]        s_hang_q, s_red_q, s_green_q;

    logic [7:0]        shadow_red_q   [8];
    logic [7:0]        shadow_green_q [8];
    logic [7:0]        com_red_q      [8];
    logic [7:0]        com_green_q    [8];

    logic              frame_valid_q, frame_changed_q, scan_err_q;
    logic [CNT_W-1:0]  frame_cnt_q, err_cnt_q;

    // Row decode of the sampled select
    logic              is_blank, is_row, is_illegal;
    logic [2:0]        row_idx;

    assign is_blank   = (s_hang_q == 8'd0);
    assign is_row     = !is_blank && ((s_hang_q & (s_hang_q - 8'd1)) == 8'd0);
    assign is_illegal = !is_blank && !is_row;

    always_comb begin
        row_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (s_hang_q[i]) row_idx = 3'(i);
        end
    end

    // Frame that a commit would publish: shadow rows 0..6 plus the row-7
    // sample that is completing the frame on this very edge.
    logic [7:0] new_red   [8];
    logic [7:0] new_green [8];
    logic [7:0] row_diff;
    logic       frame_diff;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_row
            if (gi == 7) begin : g_last
                assign new_red[gi]   = s_red_q;
                assign new_green[gi] = s_green_q;
            end else begin : g_shadow
                assign new_red[gi]   = shadow_red_q[gi];
                assign new_green[gi] = shadow_green_q[gi];
            end
            assign row_diff[gi] = (new_red[gi]   != com_red_q[gi]) ||
                                  (new_green[gi] != com_green_q[gi]);
        end
    endgenerate

    assign frame_diff = |row_diff;

    // FSM next-state / actions
    logic       wr_en, commit, err;

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        wr_en   = 1'b0;
        commit  = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            SYNC: begin
                if (is_illegal) begin
                    err = 1'b1;
                end else if (is_row && row_idx == 3'd0) begin
                    wr_en   = 1'b1;
                    exp_d   = 3'd1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (is_blank) begin
                    // blanking between rows: hold everything
                end else if (is_illegal) begin
                    err     = 1'b1;
                    state_d = SYNC;
                end else if (row_idx == exp_q - 3'd1) begin
                    wr_en = 1'b1;               // same row held another cycle
                end else if (row_idx == exp_q) begin
                    if (exp_q == 3'd7) begin
                        commit  = 1'b1;
                        state_d = SYNC;
                    end else begin
                        wr_en = 1'b1;
                        exp_d = exp_q + 3'd1;
                    end
                end else if (row_idx == 3'd0) begin
                    // early restart: drop partial frame, row 0 starts a new one
                    err   = 1'b1;
                    wr_en = 1'b1;
                    exp_d = 3'd1;
                end else begin
                    err     = 1'b1;
                    state_d = SYNC;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC;
            exp_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_hang_q        <= 8'd0;
            s_red_q         <= 8'd0;
            s_green_q       <= 8'd0;
            frame_valid_q   <= 1'b0;
            frame_changed_q <= 1'b0;
            scan_err_q      <= 1'b0;
            frame_cnt_q     <= '0;
            err_cnt_q       <= '0;
            for (int i = 0; i < 8; i++) begin
                shadow_red_q[i]   <= 8'd0;
                shadow_green_q[i] <= 8'd0;
                com_red_q[i]      <= 8'd0;
                com_green_q[i]    <= 8'd0;
            end
        end else begin
            s_hang_q  <= scan.hang ^ {8{ROW_ACTIVE_LOW}};
            s_red_q   <= scan.red;
            s_green_q <= scan.green;

            if (wr_en) begin
                shadow_red_q[row_idx]   <= s_red_q;
                shadow_green_q[row_idx] <= s_green_q;
            end
            if (commit) begin
                for (int i = 0; i < 8; i++) begin
                    com_red_q[i]   <= new_red[i];
                    com_green_q[i] <= new_green[i];
                end
            end

            frame_valid_q   <= commit;
            frame_changed_q <= commit && frame_diff;
            scan_err_q      <= err;

            if (commit && frame_cnt_q != {CNT_W{1'b1}})
                frame_cnt_q <= frame_cnt_q + 1'b1;
            if (err && err_cnt_q != {CNT_W{1'b1}})
                err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign rd_red        = com_red_q[rd_row];
    assign rd_green      = com_green_q[rd_row];
    assign frame_valid   = frame_valid_q;
    assign frame_changed = frame_changed_q;
    assign scan_err      = scan_err_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: doc/dot_matrix_scan_capture.md
Name: dot_matrix_scan_capture

Overview:
- Sink-side monitor for the 8x8 bicolor dot-matrix scan bus (row select plus red/green column lines) driven by the pattern generator.
- Samples the scan bus, checks that rows arrive in legal scan order, and reassembles a full 8x8 red/green frame.
- Publishes each completed frame to a read-port frame buffer, with a frame-complete strobe and error reporting.
- Serves as the display model for pattern-generator verification, and as the loopback checker on the board.

Parameters:
- ROW_ACTIVE_LOW, 1, 1 = the selected row is the single 0 bit in hang; 0 = the single 1 bit.
- CNT_W, 8, width of the frame and error counters (saturating).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- hang  in  8  row select; bit i selects row i.
- red  in  8  red column data for the selected row; bit j = column j; 1 = lit.
- green  in  8  green column data for the selected row; same encoding as red.
- rd_row  in  3  read address into the committed frame.
- rd_red  out  8  committed red row at rd_row, combinational read.
- rd_green  out  8  committed green row at rd_row, combinational read.
- frame_valid  out  1  one-cycle pulse when a new frame is committed.
- frame_changed  out  1  one-cycle pulse, coincident with frame_valid, when the new frame differs from the previous committed frame.
- scan_err  out  1  one-cycle pulse on an illegal or out-of-order row.
- frame_cnt  out  CNT_W  number of committed frames; saturates at all-ones.
- err_cnt  out  CNT_W  number of scan_err pulses; saturates at all-ones.

Behaviour:
- Reset: applies when rst is high at a rising edge.
  - All registers clear: sample registers, shadow buffer, committed buffer, counters and outputs.
  - Every rd_red/rd_green row reads 0. frame_valid, frame_changed and scan_err are 0.
  - FSM enters SYNC.
  - Reset mid-frame discards the partial frame.
- Input stage: hang, red and green are registered once (s_hang, s_red, s_green) at every edge. The FSM acts only on the registered copies.
- Row decode of s_hang, after inverting it when ROW_ACTIVE_LOW=1:
  - BLANK: no row selected.
  - ROW(i): exactly one bit set.
  - ILLEGAL: two or more bits set.
- FSM states: SYNC, CAPTURE. An internal 3-bit expected index `exp` tracks the next row.
- SYNC:
  - ROW(0): write shadow row 0, set exp=1, go to CAPTURE.
  - Any other ROW, or BLANK: ignored, no error.
  - ILLEGAL: scan_err pulse, stay in SYNC.
- CAPTURE:
  - BLANK: hold state and buffers.
  - ROW(exp-1), i.e. the same row held for another cycle: overwrite that shadow row, no error.
  - ROW(exp) with exp<7: write the shadow row, then exp++.
  - ROW(7) with exp=7: commit.
    - Committed buffer receives the shadow rows 0..6 plus the sampled row 7 at the same edge.
    - frame_valid=1 for the following cycle; frame_cnt++.
    - frame_changed=1 if any committed bit differs from the previous committed frame.
    - Go to SYNC.
  - ROW(0) when exp!=1: scan_err pulse, partial frame dropped, treated as the start of a new frame (write row 0, exp=1, stay in CAPTURE).
  - Any other out-of-order ROW: scan_err pulse, go to SYNC.
  - ILLEGAL: scan_err pulse, go to SYNC.
- Row 7 held after a commit: FSM is in SYNC and ignores it; no second commit.
- Latency: bus values present before edge k are sampled at edge k and acted on at edge k+1.
  - When the row-7 sample completes a frame, the committed buffer and frame_valid update at edge k+1.
  - rd_red/rd_green reflect the new frame from edge k+1 onward.
- Read port: purely combinational from the committed buffer. It never exposes the shadow buffer, so reads are never torn.
- Counters increment by 1 per event and hold at 2^CNT_W-1.
- Simultaneous events:
  - Commit and error cannot both occur on one edge.
  - rst overrides everything.

Test Plan:
1. Reset and clean frame: hold rst 2 cycles, then scan rows 0..7 one per clk (hang=8'hFE,8'hFD,...,8'h7F), red=8'h81, green=8'h18 on every row.
   - Before commit: rd_* read 0.
   - frame_valid and frame_changed pulse once, 2 edges after hang=8'h7F is applied.
   - Then every rd_row reads rd_red=8'h81, rd_green=8'h18; frame_cnt=1; err_cnt=0.
2. Repeat the identical frame: frame_valid pulses, frame_changed=0, frame_cnt=2.
3. Held rows and blanking: each row held 3 clks, with hang=8'hFF between rows.
   - Exactly one frame_valid pulse, no scan_err, data correct.
4. Out-of-order row: scan rows 0,1,2,5.
   - scan_err pulses once, err_cnt=1, no frame_valid.
   - A following clean scan 0..7 commits normally.
   - Committed data unaffected until that commit.
5. Illegal row select (hang=8'hFC) during CAPTURE: scan_err, FSM returns to SYNC.
   - A scan restart at row 3 is ignored; the next row 0 resyncs.
6. Reset mid-frame: after rows 0..4, assert rst 1 cycle, then scan rows 5..7.
   - No commit, rd_* read 0, all counters 0.
